load_extend_unit: RTL and testbench
===================================

// Module: load_extend_unit
// PURPOSE
//  Load-path data formatter between the data-memory read bus and the register-file writeback.
//  Selects the addressed byte/half/word lane from a bus beat and sign- or zero-extends it to 64 bits.
//  On a 32-bit bus, assembles a doubleword from two beats.
//  Registered, valid/ready on both sides; flags misaligned accesses and counts them.
// PARAMETERS
//  DATA_W    32     read-bus width; legal values 32 or 64 (other values: elaboration error)
//  ERR_CNT_W 8      width of saturating misalignment counter
//  OFS_W     derived localparam = log2(DATA_W/8); byte-offset width
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  in_valid    in   1          bus beat valid
//  in_ready    out  1          unit accepts beat this cycle
//  in_data     in   DATA_W     raw bus beat
//  in_ofs      in   OFS_W      byte offset of access within beat
//  in_size     in   2          00 byte, 01 half, 10 word(32), 11 double(64)
//  in_signed   in   1          1 = sign-extend, 0 = zero-extend
//  out_valid   out  1          result valid
//  out_ready   in   1          consumer accepts result
//  out_data    out  64         extended result
//  out_err     out  1          result is a misaligned access (out_data = 0)
//  err_cnt     out  ERR_CNT_W  saturating count of misaligned accesses
// BEHAVIOUR
//  - Reset (async, any state): state=S_IDLE, out_valid=0, out_data=0, out_err=0, err_cnt=0, low-word buffer=0.
//  - in_ready = ~out_valid | out_ready (in S_IDLE and S_HI alike); beat accepted when in_valid & in_ready.
//  - Lane = in_data >> (8*in_ofs). Byte: lane[7:0], sign bit lane[7]. Half: lane[15:0], sign bit lane[15].
//    Word: lane[31:0], sign bit lane[31]. Fill out_data[63:w] with sign bit if in_signed, else 0.
//  - Alignment: half needs ofs[0]=0; word needs ofs%4=0; double needs ofs=0. Byte is always aligned.
//    On violation: out_data=0, out_err=1, err_cnt+1 (saturates at all-ones); no second beat is expected.
//  - Single-beat access: result registered; out_valid rises the cycle after acceptance (latency 1).
//    Throughput 1/cycle under continuous out_ready.
//  - Double, DATA_W=64: single beat; out_data=in_data; in_signed ignored.
//  - Double, DATA_W=32, FSM:
//      S_IDLE -> S_HI on accepted aligned double beat; that beat stored as low word. No output produced.
//      S_HI   -> S_IDLE on next accepted beat; out_data={beat,low}; out_valid next cycle.
//      In S_HI, in_ofs/in_size/in_signed of the beat are ignored.
//  - Output holds (out_data, out_err stable) while out_valid & ~out_ready.
//    out_valid drops after a handshake unless a new result is loaded in the same cycle.
//  - Simultaneous out handshake + in accept: the new result replaces the old with no bubble.
//  - Reset asserted in S_HI: the buffered low word is discarded; no partial result is ever emitted.
//  - in_size/ofs values outside legal encodings cannot occur: all 2-bit sizes are defined.
// STRUCTURE
//  - Shared package arm_mem_pkg: size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10,
//    SZ_DWORD=2'b11; state encodings S_IDLE/S_HI.
//  - One combinational sub-module lane_extend (in: data, ofs, size, signed; out: 64-bit value,
//    misaligned flag). The parent holds the FSM, low-word buffer, output register, handshake and
//    err_cnt.
// TESTING
//  1. DATA_W=32, in_data=32'h1234_80F0, ofs=0, byte, signed -> next cycle out_data=64'hFFFF_FFFF_FFFF_FFF0, err=0.
//  2. Same beat, ofs=2, half, unsigned -> out_data=64'h0000_0000_0000_1234;
//     half signed with ofs=1 -> out_err=1, out_data=0, err_cnt=1.
//  3. DATA_W=32 double: beat0 32'hDEAD_BEEF, ofs=0, then beat1 32'h0123_4567 ->
//     single output 64'h0123_4567_DEAD_BEEF; no output after beat0.
//  4. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable;
//     out_ready=1 -> back-to-back results, no bubble.
//  5. Assert reset while in S_HI -> all outputs 0 immediately.
//     Next double beat pair -> correct result; stale low word never appears.
//  6. DATA_W=64: in_data=64'h8000_0000_0000_0000, ofs=4, word, signed -> 64'hFFFF_FFFF_8000_0000.
//     Then 300 misaligned accesses -> err_cnt saturates at 8'hFF.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared load-path encodings: access sizes and the
// doubleword-assembly FSM states.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HI   = 1'b1
    } state_e;

endpackage

// File: rtl/lane_extend.sv
// Combinational lane select + sign/zero extension to 64 bits.
// Ports: i_data/i_ofs/i_size/i_signed in; o_value, o_misaligned out.
// A misaligned access forces o_value to zero.
module lane_extend
    import arm_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFS_W  = 2
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [OFS_W-1:0]  i_ofs,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [63:0]       o_value,
    output logic              o_misaligned
);

    logic [31:0] w_lane;
    logic [63:0] w_value;
    logic        w_mis;

    always_comb begin
        w_lane  = 32'(i_data >> {i_ofs, 3'b000});
        w_value = '0;
        w_mis   = 1'b0;
        unique case (size_e'(i_size))
            SZ_BYTE: begin
                w_value = {{56{i_signed & w_lane[7]}}, w_lane[7:0]};
            end
            SZ_HALF: begin
                w_mis   = i_ofs[0];
                w_value = {{48{i_signed & w_lane[15]}}, w_lane[15:0]};
            end
            SZ_WORD: begin
                w_mis   = |i_ofs[1:0];
                w_value = {{32{i_signed & w_lane[31]}}, w_lane};
            end
            SZ_DWORD: begin
                // Wide bus: whole beat; narrow bus: parent assembles
                w_mis   = |i_ofs;
                w_value = 64'(i_data);
            end
        endcase
        if (w_mis) begin
            w_value = '0;
        end
    end

    assign o_value      = w_value;
    assign o_misaligned = w_mis;

endmodule

// File: rtl/load_extend_unit.sv
// Load-path formatter: lane select, extension, 2-beat doubleword assembly.
// Ports: clk/reset; in_* beat handshake; out_* result handshake; err_cnt.
module load_extend_unit
    import arm_mem_pkg::*;
#(
    parameter int   DATA_W    = 32,
    parameter int   ERR_CNT_W = 8,
    localparam int  OFS_W     = $clog2(DATA_W / 8)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [OFS_W-1:0]     in_ofs,
    input  logic [1:0]           in_size,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("load_extend_unit: DATA_W must be 32 or 64");
    end

    // Doublewords need two beats only on the narrow bus
    localparam bit SPLIT = (DATA_W == 32);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [31:0]           r_lo;
    logic                  r_out_valid;
    logic [63:0]           r_out_data;
    logic                  r_out_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic [63:0] w_value;
    logic        w_mis;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_load;
    logic [63:0] w_data;
    logic        w_err;
    logic        w_err_inc;
    logic        w_lo_wr;

    lane_extend #(
        .DATA_W (DATA_W),
        .OFS_W  (OFS_W)
    ) u_lane (
        .i_data       (in_data),
        .i_ofs        (in_ofs),
        .i_size       (in_size),
        .i_signed     (in_signed),
        .o_value      (w_value),
        .o_misaligned (w_mis)
    );

    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_accept   = in_valid & w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_data      = '0;
        w_err       = 1'b0;
        w_err_inc   = 1'b0;
        w_lo_wr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_mis) begin
                        w_load    = 1'b1;
                        w_err     = 1'b1;
                        w_err_inc = 1'b1;
                    end else if (SPLIT &&
                                 size_e'(in_size) == SZ_DWORD) begin
                        w_lo_wr     = 1'b1;
                        w_state_nxt = S_HI;
                    end else begin
                        w_load = 1'b1;
                        w_data = w_value;
                    end
                end
            end
            S_HI: begin
                // Attributes of the high beat are irrelevant
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_data      = {in_data[31:0], r_lo};
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_lo_wr) begin
                r_lo <= in_data[31:0];
            end
            r_out_valid <= w_load | (r_out_valid & ~out_ready);
            if (w_load) begin
                r_out_data <= w_data;
                r_out_err  <= w_err;
            end
            if (w_err_inc && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed bench for load_extend_unit: 32-bit and 64-bit bus instances,
// hand-computed expected results.
module tb_load_extend_unit;
    import arm_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // 32-bit bus instance
    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_in_data;
    logic [1:0]  a_in_ofs;
    logic [1:0]  a_in_size;
    logic        a_in_signed;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [63:0] a_out_data;
    logic        a_out_err;
    logic [7:0]  a_err_cnt;

    // 64-bit bus instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [63:0] b_in_data;
    logic [2:0]  b_in_ofs;
    logic [1:0]  b_in_size;
    logic        b_in_signed;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [63:0] b_out_data;
    logic        b_out_err;
    logic [7:0]  b_err_cnt;

    load_extend_unit #(.DATA_W(32), .ERR_CNT_W(8)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_ofs    (a_in_ofs),
        .in_size   (a_in_size),
        .in_signed (a_in_signed),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_err   (a_out_err),
        .err_cnt   (a_err_cnt)
    );

    load_extend_unit #(.DATA_W(64), .ERR_CNT_W(8)) u_dut64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_ofs    (b_in_ofs),
        .in_size   (b_in_size),
        .in_signed (b_in_signed),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_err   (b_out_err),
        .err_cnt   (b_err_cnt)
    );

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One accepted beat on the 32-bit instance; returns at edge+1
    task automatic beat32(input logic [31:0] d, input logic [1:0] ofs,
                          input logic [1:0] sz, input logic sg);
        a_in_data   = d;
        a_in_ofs    = ofs;
        a_in_size   = sz;
        a_in_signed = sg;
        a_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
    endtask

    task automatic beat64(input logic [63:0] d, input logic [2:0] ofs,
                          input logic [1:0] sz, input logic sg);
        b_in_data   = d;
        b_in_ofs    = ofs;
        b_in_size   = sz;
        b_in_signed = sg;
        b_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_in_ofs    = '0;
        a_in_size   = '0;
        a_in_signed = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_ofs    = '0;
        b_in_size   = '0;
        b_in_signed = 1'b0;
        b_out_ready = 1'b1;

        #12;
        chk("rst_valid", 64'(a_out_valid), 64'd0);
        chk("rst_data", a_out_data, 64'd0);
        chk("rst_err", 64'(a_out_err), 64'd0);
        chk("rst_cnt", 64'(a_err_cnt), 64'd0);
        chk("rst_data64", b_out_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // signed byte
        beat32(32'h1234_80F0, 2'd0, SZ_BYTE, 1'b1);
        chk("byte_valid", 64'(a_out_valid), 64'd1);
        chk("byte_s", a_out_data, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("byte_err", 64'(a_out_err), 64'd0);

        // unsigned half at offset 2
        beat32(32'h1234_80F0, 2'd2, SZ_HALF, 1'b0);
        chk("half_u", a_out_data, 64'h0000_0000_0000_1234);

        // misaligned half
        beat32(32'h1234_80F0, 2'd1, SZ_HALF, 1'b1);
        chk("mis_err", 64'(a_out_err), 64'd1);
        chk("mis_data", a_out_data, 64'd0);
        chk("mis_cnt", 64'(a_err_cnt), 64'd1);

        // misaligned double: error, no second beat awaited
        beat32(32'h1234_80F0, 2'd2, SZ_DWORD, 1'b0);
        chk("misd_err", 64'(a_out_err), 64'd1);
        chk("misd_cnt", 64'(a_err_cnt), 64'd2);
        beat32(32'h1234_80F0, 2'd0, SZ_BYTE, 1'b0);
        chk("after_misd", a_out_data, 64'h0000_0000_0000_00F0);
        chk("after_misd_v", 64'(a_out_valid), 64'd1);

        // two-beat doubleword
        beat32(32'hDEAD_BEEF, 2'd0, SZ_DWORD, 1'b0);
        chk("dw_no_out", 64'(a_out_valid), 64'd0);
        beat32(32'h0123_4567, 2'd3, SZ_BYTE, 1'b1);
        chk("dw_valid", 64'(a_out_valid), 64'd1);
        chk("dw_data", a_out_data, 64'h0123_4567_DEAD_BEEF);
        chk("dw_err", 64'(a_out_err), 64'd0);
        @(posedge clk);
        #1;
        chk("dw_single", 64'(a_out_valid), 64'd0);

        // back-pressure
        a_out_ready = 1'b0;
        beat32(32'h1234_80F0, 2'd1, SZ_BYTE, 1'b0);
        chk("bp_first", a_out_data, 64'h0000_0000_0000_0080);
        a_in_data   = 32'h1234_80F0;
        a_in_ofs    = 2'd3;
        a_in_size   = SZ_BYTE;
        a_in_signed = 1'b0;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_rdy", 64'(a_in_ready), 64'd0);
            chk("bp_hold", a_out_data, 64'h0000_0000_0000_0080);
            chk("bp_valid", 64'(a_out_valid), 64'd1);
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_v0", 64'(a_out_valid), 64'd1);
        chk("b2b_d0", a_out_data, 64'h0000_0000_0000_0012);
        a_in_ofs    = 2'd0;
        a_in_size   = SZ_HALF;
        a_in_signed = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_v1", 64'(a_out_valid), 64'd1);
        chk("b2b_d1", a_out_data, 64'hFFFF_FFFF_FFFF_80F0);
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_drain", 64'(a_out_valid), 64'd0);

        // reset in S_HI
        beat32(32'hCAFE_F00D, 2'd0, SZ_DWORD, 1'b0);
        reset = 1'b1;
        #1;
        chk("rhi_valid", 64'(a_out_valid), 64'd0);
        chk("rhi_data", a_out_data, 64'd0);
        chk("rhi_cnt", 64'(a_err_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        beat32(32'h1111_2222, 2'd0, SZ_DWORD, 1'b0);
        chk("rhi_no_out", 64'(a_out_valid), 64'd0);
        beat32(32'h3333_4444, 2'd0, SZ_DWORD, 1'b0);
        chk("rhi_dw", a_out_data, 64'h3333_4444_1111_2222);
        chk("rhi_dw_v", 64'(a_out_valid), 64'd1);

        // 64-bit bus
        beat64(64'h8000_0000_0000_0000, 3'd4, SZ_WORD, 1'b1);
        chk("w64_s", b_out_data, 64'hFFFF_FFFF_8000_0000);
        chk("w64_v", 64'(b_out_valid), 64'd1);
        beat64(64'h8123_4567_89AB_CDEF, 3'd0, SZ_DWORD, 1'b1);
        chk("d64", b_out_data, 64'h8123_4567_89AB_CDEF);
        beat64(64'h8123_4567_89AB_CDEF, 3'd2, SZ_WORD, 1'b0);
        chk("w64_mis", 64'(b_out_err), 64'd1);
        chk("w64_mis_cnt", 64'(b_err_cnt), 64'd1);
        for (int i = 0; i < 299; i++) begin
            beat64(64'h0, 3'd1, SZ_HALF, 1'b0);
            if (i == 252) begin
                chk("cnt_254", 64'(b_err_cnt), 64'd254);
            end
        end
        chk("cnt_sat", 64'(b_err_cnt), 64'hFF);
        chk("sat_err", 64'(b_out_err), 64'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
